fpu_round_arbiter: RTL and testbench

FPU_ROUND_ARBITER -- requirements
Module: fpu_round_arbiter

---
 rtl/fpu_pkg.sv | 29 ++
 rtl/unit_rounding.sv | 38 +++
 rtl/fpu_round_arbiter.sv | 128 ++++++++++++
 tb/tb_fpu_round_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared widths, request/result types and the round-up test
package fpu_pkg;

    localparam int EXP_W      = 8;
    localparam int MANT_IN_W  = 28;
    localparam int MANT_OUT_W = 23;

    typedef struct packed {
        logic                 sign;
        logic [EXP_W-1:0]     exp;
        logic [MANT_IN_W-1:0] mant;
        logic                 ov;
        logic                 un;
    } round_req_t;

    typedef struct packed {
        logic                  sign;
        logic [EXP_W-1:0]      exp;
        logic [MANT_OUT_W-1:0] mant;
        logic                  ov;
        logic                  un;
    } round_res_t;

    // Round to nearest even: m[4] is the kept lsb, m[3] guard, m[2:0] sticky.
    function automatic logic round_up(input logic ov, input logic [MANT_IN_W-1:0] m);
        return ~ov & (m[4] ? m[3] : (m[3] & (|m[2:0])));
    endfunction

endpackage

// File: rtl/unit_rounding.sv
// rtl/unit_rounding.sv - combinational round-to-nearest-even with renormalisation
module unit_rounding
    import fpu_pkg::*;
(
    input  round_req_t req,
    output round_res_t res,
    output logic       r_up
);

    logic [MANT_OUT_W:0] sum;
    logic                unused_msb;

    assign unused_msb = req.mant[MANT_IN_W-1];

    always_comb begin
        r_up     = round_up(req.ov, req.mant);
        sum      = {1'b0, req.mant[26:4]} + {{MANT_OUT_W{1'b0}}, 1'b1};
        res.sign = req.sign;
        res.exp  = req.exp;
        res.mant = req.mant[26:4];
        res.ov   = req.ov;
        res.un   = req.un;
        if (r_up) begin
            res.mant = sum[MANT_OUT_W-1:0];
            // Mantissa carry-out: fraction wraps to zero and the exponent bumps,
            // saturating to an overflowed all-ones exponent.
            if (sum[MANT_OUT_W]) begin
                if (req.exp >= 8'hFE) begin
                    res.exp = 8'hFF;
                    res.ov  = 1'b1;
                end else begin
                    res.exp = req.exp + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/fpu_round_arbiter.sv
// rtl/fpu_round_arbiter.sv - two-requester shared rounding stage; FPU_ROUND_RR_EN selects round-robin
module fpu_round_arbiter
    import fpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [1:0]            i_req_valid,
    output logic [1:0]            o_req_ready,
    input  logic                  i_sign0,
    input  logic                  i_sign1,
    input  logic [EXP_W-1:0]      i_exp0,
    input  logic [EXP_W-1:0]      i_exp1,
    input  logic [MANT_IN_W-1:0]  i_mant0,
    input  logic [MANT_IN_W-1:0]  i_mant1,
    input  logic                  i_ov0,
    input  logic                  i_ov1,
    input  logic                  i_un0,
    input  logic                  i_un1,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_sign,
    output logic [EXP_W-1:0]      o_exp,
    output logic [MANT_OUT_W-1:0] o_mant,
    output logic                  o_ov_fl,
    output logic                  o_un_fl,
    output logic                  o_id,
    input  logic                  i_cnt_clr,
    output logic [CNT_W-1:0]      o_rnd_cnt
);

    logic       va, vb;
    logic       rdy_a, rdy_b;
    logic       a_id, b_id, b_rup;
    logic       gnt_id, acc;
    round_req_t a_req, req0, req1;
    round_res_t b_res, rnd_res;
    logic       rnd_up;
    logic [CNT_W-1:0] cnt;

    assign req0 = '{sign: i_sign0, exp: i_exp0, mant: i_mant0, ov: i_ov0, un: i_un0};
    assign req1 = '{sign: i_sign1, exp: i_exp1, mant: i_mant1, ov: i_ov1, un: i_un1};

    assign rdy_b = ~vb | i_ready;
    assign rdy_a = ~va | rdy_b;
    // Reset gates the grant so no requester sees ready while the pipe is held clear.
    assign acc   = rdy_a & (|i_req_valid) & i_rst_n;

`ifdef FPU_ROUND_RR_EN
    logic last_gnt;

    always_comb begin
        gnt_id = i_req_valid[1];
        if (&i_req_valid) begin
            gnt_id = ~last_gnt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_gnt <= 1'b1;
        end else if (acc) begin
            last_gnt <= gnt_id;
        end
    end
`else
    assign gnt_id = ~i_req_valid[0];
`endif

    assign o_req_ready = acc ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            va    <= 1'b0;
            a_id  <= 1'b0;
            a_req <= '0;
        end else if (rdy_a) begin
            va <= acc;
            if (acc) begin
                a_req <= gnt_id ? req1 : req0;
                a_id  <= gnt_id;
            end
        end
    end

    unit_rounding u_rounding (
        .req  (a_req),
        .res  (rnd_res),
        .r_up (rnd_up)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vb    <= 1'b0;
            b_id  <= 1'b0;
            b_rup <= 1'b0;
            b_res <= '0;
        end else if (rdy_b) begin
            vb <= va;
            if (va) begin
                b_res <= rnd_res;
                b_id  <= a_id;
                b_rup <= rnd_up;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_cnt_clr) begin
            cnt <= '0;
        end else if (vb && i_ready && b_rup && !(&cnt)) begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_valid   = vb;
    assign o_sign    = b_res.sign;
    assign o_exp     = b_res.exp;
    assign o_mant    = b_res.mant;
    assign o_ov_fl   = b_res.ov;
    assign o_un_fl   = b_res.un;
    assign o_id      = b_id;
    assign o_rnd_cnt = cnt;

endmodule

// File: tb/tb_fpu_round_arbiter.sv
// tb/tb_fpu_round_arbiter.sv - vector table plus scoreboard bench for fpu_round_arbiter
module tb_fpu_round_arbiter;

    localparam int CW = 2;

    logic        i_clk, i_rst_n;
    logic [1:0]  i_req_valid, o_req_ready;
    logic        i_sign0, i_sign1;
    logic [7:0]  i_exp0, i_exp1;
    logic [27:0] i_mant0, i_mant1;
    logic        i_ov0, i_ov1, i_un0, i_un1;
    logic        o_valid, i_ready;
    logic        o_sign;
    logic [7:0]  o_exp;
    logic [22:0] o_mant;
    logic        o_ov_fl, o_un_fl, o_id;
    logic        i_cnt_clr;
    logic [CW-1:0] o_rnd_cnt;

    fpu_round_arbiter #(.CNT_W(CW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_sign0(i_sign0), .i_sign1(i_sign1),
        .i_exp0(i_exp0), .i_exp1(i_exp1),
        .i_mant0(i_mant0), .i_mant1(i_mant1),
        .i_ov0(i_ov0), .i_ov1(i_ov1), .i_un0(i_un0), .i_un1(i_un1),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_sign(o_sign), .o_exp(o_exp), .o_mant(o_mant),
        .o_ov_fl(o_ov_fl), .o_un_fl(o_un_fl), .o_id(o_id),
        .i_cnt_clr(i_cnt_clr), .o_rnd_cnt(o_rnd_cnt)
    );

    typedef struct {
        logic        id;
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
        logic        ov;
        logic        un;
    } res_t;

    typedef struct {
        logic        id;
        logic        sign;
        logic [7:0]  exp;
        logic [27:0] mant;
        logic        ov;
        logic        un;
        res_t        res;
        logic        rup;
    } vec_t;

    vec_t vtab [9];
    res_t sb_q [$];
    res_t pend [2];
    logic gseq [$];
    int   errors = 0;
    int   checks = 0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard: push on request acceptance, pop and compare on output transfer.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (i_req_valid[k] && o_req_ready[k]) sb_q.push_back(pend[k]);
            end
            if (o_valid && i_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_output", 64'd1, 64'd0);
                end else begin
                    res_t r;
                    r = sb_q.pop_front();
                    chk("sb_result", {o_id, o_sign, o_exp, o_mant, o_ov_fl, o_un_fl},
                        {r.id, r.sign, r.exp, r.mant, r.ov, r.un});
                end
            end
        end
    end

    task automatic set_req(input int k, input vec_t v);
        res_t r;
        r = v.res;
        r.id = k[0];
        if (k == 0) begin
            i_sign0 = v.sign; i_exp0 = v.exp; i_mant0 = v.mant; i_ov0 = v.ov; i_un0 = v.un;
            pend[0] = r;
        end else begin
            i_sign1 = v.sign; i_exp1 = v.exp; i_mant1 = v.mant; i_ov1 = v.ov; i_un1 = v.un;
            pend[1] = r;
        end
    endtask

    task automatic run_reqs(input int n0, input int n1, input int total);
        int need [2];
        int got;
        int cyc;
        need[0] = n0;
        need[1] = n1;
        got = 0;
        cyc = 0;
        i_req_valid = {need[1] > 0, need[0] > 0};
        while (got < total && cyc < 60) begin
            @(negedge i_clk);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (i_req_valid[k] && o_req_ready[k]) begin
                    need[k]--;
                    got++;
                    gseq.push_back(k[0]);
                end
            end
            @(posedge i_clk);
            #1;
            i_req_valid = {need[1] > 0 && got < total, need[0] > 0 && got < total};
        end
        i_req_valid = 2'b00;
        chk("grant_count", got, total);
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (sb_q.size() != 0 && cyc < 60) begin
            @(negedge i_clk);
            cyc++;
        end
        @(posedge i_clk);
        #1;
        chk("drain_left", sb_q.size(), 0);
    endtask

    task automatic pulse_clr();
        i_cnt_clr = 1'b1;
        @(posedge i_clk);
        #1;
        i_cnt_clr = 1'b0;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_req_valid = 2'b00;
        repeat (2) @(posedge i_clk);
        #1;
        sb_q.delete();
        i_rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  exp_seq;
        logic [63:0] snap;
        int          cyc;

        vtab[0] = '{1'b0, 1'b0, 8'h80, 28'h0000018, 1'b0, 1'b0, '{1'b0, 1'b0, 8'h80, 23'h000002, 1'b0, 1'b0}, 1'b1};
        vtab[1] = '{1'b1, 1'b1, 8'h10, 28'h0000028, 1'b0, 1'b0, '{1'b1, 1'b1, 8'h10, 23'h000002, 1'b0, 1'b0}, 1'b0};
        vtab[2] = '{1'b0, 1'b0, 8'h7F, 28'h0000029, 1'b0, 1'b0, '{1'b0, 1'b0, 8'h7F, 23'h000003, 1'b0, 1'b0}, 1'b1};
        vtab[3] = '{1'b1, 1'b0, 8'h22, 28'h0000037, 1'b0, 1'b0, '{1'b1, 1'b0, 8'h22, 23'h000003, 1'b0, 1'b0}, 1'b0};
        vtab[4] = '{1'b0, 1'b1, 8'h40, 28'h7FFFFF8, 1'b0, 1'b0, '{1'b0, 1'b1, 8'h41, 23'h000000, 1'b0, 1'b0}, 1'b1};
        vtab[5] = '{1'b1, 1'b0, 8'hFE, 28'h7FFFFF8, 1'b0, 1'b0, '{1'b1, 1'b0, 8'hFF, 23'h000000, 1'b1, 1'b0}, 1'b1};
        vtab[6] = '{1'b1, 1'b0, 8'hFF, 28'h123456F, 1'b1, 1'b0, '{1'b1, 1'b0, 8'hFF, 23'h123456, 1'b1, 1'b0}, 1'b0};
        vtab[7] = '{1'b0, 1'b0, 8'h00, 28'h0000004, 1'b0, 1'b1, '{1'b0, 1'b0, 8'h00, 23'h000000, 1'b0, 1'b1}, 1'b0};
        vtab[8] = '{1'b1, 1'b1, 8'h01, 28'h000001C, 1'b0, 1'b1, '{1'b1, 1'b1, 8'h01, 23'h000002, 1'b0, 1'b1}, 1'b1};

        i_rst_n = 1'b0;
        i_req_valid = 2'b11;
        i_ready = 1'b1;
        i_cnt_clr = 1'b0;
        set_req(0, vtab[0]);
        set_req(1, vtab[1]);
        repeat (2) @(posedge i_clk);
        #3;
        chk("rst_o_valid", o_valid, 1'b0);
        chk("rst_req_ready", o_req_ready, 2'b00);
        chk("rst_rnd_cnt", o_rnd_cnt, 0);
        chk("rst_result", {o_id, o_sign, o_exp, o_mant, o_ov_fl, o_un_fl}, 0);
        i_req_valid = 2'b00;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            pulse_clr();
            set_req(int'(vtab[i].id), vtab[i]);
            run_reqs(vtab[i].id ? 0 : 1, vtab[i].id ? 1 : 0, 1);
            drain();
            chk($sformatf("vec%0d_rnd_cnt", i), o_rnd_cnt, {1'b0, vtab[i].rup});
        end

        do_reset();
        gseq.delete();
        set_req(0, vtab[0]);
        set_req(1, vtab[1]);
        run_reqs(99, 99, 4);
        drain();
`ifdef FPU_ROUND_RR_EN
        exp_seq = 4'b1010;
`else
        exp_seq = 4'b0000;
`endif
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("contention_id%0d", i), gseq[i], exp_seq[i]);
        end

        i_ready = 1'b0;
        set_req(0, vtab[2]);
        set_req(1, vtab[3]);
        run_reqs(1, 1, 2);
        i_req_valid = 2'b11;
        @(negedge i_clk);
        chk("stall_o_valid", o_valid, 1'b1);
        snap = {o_id, o_sign, o_exp, o_mant, o_ov_fl, o_un_fl};
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("stall_req_ready%0d", c), o_req_ready, 2'b00);
            chk($sformatf("stall_hold%0d", c), {o_valid, o_id, o_sign, o_exp, o_mant, o_ov_fl, o_un_fl},
                {1'b1, snap[34:0]});
            @(negedge i_clk);
        end
        @(posedge i_clk);
        #1;
        i_req_valid = 2'b00;
        i_ready = 1'b1;
        drain();

        pulse_clr();
        set_req(0, vtab[0]);
        run_reqs(5, 0, 5);
        drain();
        chk("cnt_saturate", o_rnd_cnt, 2'd3);

        i_ready = 1'b0;
        run_reqs(1, 0, 1);
        cyc = 0;
        while (!o_valid && cyc < 20) begin
            @(negedge i_clk);
            cyc++;
        end
        chk("clr_wait_valid", o_valid, 1'b1);
        @(posedge i_clk);
        #1;
        chk("cnt_before_clr", o_rnd_cnt, 2'd3);
        i_ready = 1'b1;
        i_cnt_clr = 1'b1;
        @(posedge i_clk);
        #1;
        i_cnt_clr = 1'b0;
        chk("cnt_clr_priority", o_rnd_cnt, 2'd0);
        drain();

        i_ready = 1'b0;
        set_req(0, vtab[4]);
        set_req(1, vtab[5]);
        run_reqs(1, 1, 2);
        @(negedge i_clk);
        chk("midrst_pre_valid", o_valid, 1'b1);
        i_req_valid = 2'b11;
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("midrst_o_valid", o_valid, 1'b0);
        chk("midrst_req_ready", o_req_ready, 2'b00);
        sb_q.delete();
        i_req_valid = 2'b00;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        gseq.delete();
        set_req(0, vtab[6]);
        set_req(1, vtab[7]);
        run_reqs(1, 1, 2);
        drain();
        chk("midrst_first_grant", gseq[0], 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
